// File: rtl/hazard_control.sv
// Pipeline sequencer for the 5-stage MIPS core: load-use stalls, taken-branch flushes,
// instruction-memory wait states, and a saturating lost-cycle counter.
module hazard_control #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       ID_Rs_In,
   input  logic [4:0]       ID_Rt_In,
   input  logic             ID_UsesRt_In,
   input  logic [4:0]       EX_Rt_In,
   input  logic             EX_MemRead_In,
   input  logic             EX_BranchTaken_In,
   input  logic             IMem_Ready_In,
   output logic             PCWrite_Out,
   output logic             IF_IDWrite_Out,
   output logic             ID_EX_Bubble_Out,
   output logic [1:0]       State_Out,
   output logic [CNT_W-1:0] Stall_Count_Out
);

   localparam int unsigned FC_W = 3;
   localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_FLUSH    = 2'd2,
      ST_FWAIT    = 2'd3
   } state_t;

   // A single-cycle flush never needs the FLUSH state
   localparam state_t ST_AFTER_BR = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [FC_W-1:0]   r_flush_cnt;
   logic [FC_W-1:0]   w_flush_cnt_nxt;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic w_lu;
   logic w_br;
   logic w_fw;
   logic w_pc_write;
   logic w_ifid_write;
   logic w_bubble;
   logic w_lost;

   assign w_lu = EX_MemRead_In && (EX_Rt_In != 5'd0) &&
                 ((EX_Rt_In == ID_Rs_In) || (ID_UsesRt_In && (EX_Rt_In == ID_Rt_In)));
   assign w_br = EX_BranchTaken_In;
   assign w_fw = !IMem_Ready_In;

   // Next-state and pipeline controls; priority br > lu > fw
   always_comb begin
      w_pc_write      = 1'b1;
      w_ifid_write    = 1'b0;
      w_bubble        = 1'b0;
      w_state_nxt     = r_state;
      w_flush_cnt_nxt = r_flush_cnt;
      case (r_state)
         ST_FLUSH: begin
            w_pc_write   = IMem_Ready_In;
            w_ifid_write = 1'b1;
            w_bubble     = 1'b1;
            if (w_br) begin
               w_state_nxt     = ST_AFTER_BR;
               w_flush_cnt_nxt = FLUSH_RELOAD;
            end else if (r_flush_cnt <= FC_W'(1)) begin
               w_state_nxt     = ST_RUN;
               w_flush_cnt_nxt = '0;
            end else begin
               w_flush_cnt_nxt = r_flush_cnt - FC_W'(1);
            end
         end
         default: begin
            if (w_br) begin
               w_ifid_write    = 1'b1;
               w_bubble        = 1'b1;
               w_state_nxt     = ST_AFTER_BR;
               w_flush_cnt_nxt = FLUSH_RELOAD;
            end else if ((r_state == ST_FWAIT) && w_fw) begin
               w_pc_write   = 1'b0;
               w_ifid_write = 1'b1;
               w_state_nxt  = ST_FWAIT;
            end else if (w_lu && (r_state != ST_LU_STALL)) begin
               // The bubble already cleared EX_MemRead, so LU_STALL ignores lu
               w_pc_write  = 1'b0;
               w_bubble    = 1'b1;
               w_state_nxt = ST_LU_STALL;
            end else if (w_fw) begin
               w_pc_write   = 1'b0;
               w_ifid_write = 1'b1;
               w_state_nxt  = ST_FWAIT;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
      endcase
   end

   assign w_lost = !w_pc_write || w_ifid_write;

   // State, flush counter and saturating lost-cycle counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= ST_RUN;
         r_flush_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
         if (w_lost && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign PCWrite_Out      = w_pc_write;
   assign IF_IDWrite_Out   = w_ifid_write;
   assign ID_EX_Bubble_Out = w_bubble;
   assign State_Out        = r_state;
   assign Stall_Count_Out  = r_stall_cnt;

endmodule

// File: tb/tb_hazard_control.sv
// Bench for hazard_control: directed scenarios plus random stimulus against a reference model,
// run on two instances (FLUSH_CYCLES=2/CNT_W=16 and FLUSH_CYCLES=3/CNT_W=4).
module tb_hazard_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_uses_rt;
   logic [4:0] ex_rt;
   logic       ex_memread;
   logic       ex_br;
   logic       imem_ready;

   logic        pc_a, ifid_a, bub_a;
   logic [1:0]  st_a;
   logic [15:0] cnt_a;
   logic        pc_b, ifid_b, bub_b;
   logic [1:0]  st_b;
   logic [3:0]  cnt_b;

   int n_checks = 0;
   int n_fail   = 0;

   int m_mode[2];
   int m_left[2];
   int m_cnt[2];
   int fcyc[2] = '{2, 3};
   int cmax[2] = '{65535, 15};

   always #5 clk = ~clk;

   hazard_control #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .ID_Rs_In(id_rs), .ID_Rt_In(id_rt), .ID_UsesRt_In(id_uses_rt),
      .EX_Rt_In(ex_rt), .EX_MemRead_In(ex_memread), .EX_BranchTaken_In(ex_br),
      .IMem_Ready_In(imem_ready), .PCWrite_Out(pc_a), .IF_IDWrite_Out(ifid_a),
      .ID_EX_Bubble_Out(bub_a), .State_Out(st_a), .Stall_Count_Out(cnt_a));

   hazard_control #(.FLUSH_CYCLES(3), .CNT_W(4)) dut_s (
      .clk(clk), .reset(reset), .ID_Rs_In(id_rs), .ID_Rt_In(id_rt), .ID_UsesRt_In(id_uses_rt),
      .EX_Rt_In(ex_rt), .EX_MemRead_In(ex_memread), .EX_BranchTaken_In(ex_br),
      .IMem_Ready_In(imem_ready), .PCWrite_Out(pc_b), .IF_IDWrite_Out(ifid_b),
      .ID_EX_Bubble_Out(bub_b), .State_Out(st_b), .Stall_Count_Out(cnt_b));

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: mode 0 RUN, 1 LU_STALL, 2 FLUSH, 3 FWAIT; left = remaining flush cycles
   function automatic void predict(input int fc, input int mode, input int left,
                                   output int pc, output int ifid, output int bub,
                                   output int nmode, output int nleft);
      bit lu, br, fw;
      lu = ex_memread && (ex_rt != 0) && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
      br = ex_br;
      fw = !imem_ready;
      nleft = 0;
      nmode = mode;
      if (mode == 2) begin
         pc = int'(imem_ready); ifid = 1; bub = 1;
         nleft = br ? fc - 1 : left - 1;
         if (nleft < 0) nleft = 0;
         nmode = (nleft > 0) ? 2 : 0;
      end else if (br) begin
         pc = 1; ifid = 1; bub = 1;
         nleft = fc - 1;
         nmode = (nleft > 0) ? 2 : 0;
      end else if (mode == 3 && fw) begin
         pc = 0; ifid = 1; bub = 0; nmode = 3;
      end else if (lu && mode != 1) begin
         pc = 0; ifid = 0; bub = 1; nmode = 1;
      end else if (fw) begin
         pc = 0; ifid = 1; bub = 0; nmode = 3;
      end else begin
         pc = 1; ifid = 0; bub = 0; nmode = 0;
      end
   endfunction

   task automatic set_in(input bit rst, input int rs, input int rt, input bit uses,
                         input int xrt, input bit mr, input bit br, input bit rdy);
      reset      = rst;
      id_rs      = 5'(rs);
      id_rt      = 5'(rt);
      id_uses_rt = uses;
      ex_rt      = 5'(xrt);
      ex_memread = mr;
      ex_br      = br;
      imem_ready = rdy;
   endtask

   // One clock: check combinational outputs, advance, check registered state/count
   task automatic cycle(input string tag);
      int pc, ifid, bub, nm, nl;
      int nmode[2], nleft[2], ncnt[2];
      #1;
      for (int k = 0; k < 2; k++) begin
         predict(fcyc[k], m_mode[k], m_left[k], pc, ifid, bub, nm, nl);
         check($sformatf("%s.pc%0d", tag, k),   int'(k == 0 ? pc_a : pc_b), pc);
         check($sformatf("%s.ifid%0d", tag, k), int'(k == 0 ? ifid_a : ifid_b), ifid);
         check($sformatf("%s.bub%0d", tag, k),  int'(k == 0 ? bub_a : bub_b), bub);
         if (!reset) begin
            nmode[k] = 0; nleft[k] = 0; ncnt[k] = 0;
         end else begin
            nmode[k] = nm; nleft[k] = nl;
            ncnt[k]  = (pc == 0 || ifid == 1) ? m_cnt[k] + 1 : m_cnt[k];
            if (ncnt[k] > cmax[k]) ncnt[k] = cmax[k];
         end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = nmode[k];
         m_left[k] = nleft[k];
         m_cnt[k]  = ncnt[k];
      end
      check({tag, ".st0"},  int'(st_a),  m_mode[0]);
      check({tag, ".cnt0"}, int'(cnt_a), m_cnt[0]);
      check({tag, ".st1"},  int'(st_b),  m_mode[1]);
      check({tag, ".cnt1"}, int'(cnt_b), m_cnt[1]);
   endtask

   initial begin
      set_in(0, 0, 0, 0, 0, 0, 1, 1);
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = 0; m_left[k] = 0; m_cnt[k] = 0;
      end

      // Reset held with br asserted
      repeat (3) cycle("rst");
      check("rst_state", int'(st_a), 0);
      check("rst_count", int'(cnt_a), 0);
      set_in(1, 1, 2, 1, 3, 0, 0, 1);
      #1;
      check("run_pc", int'(pc_a), 1);
      check("run_ifid", int'(ifid_a), 0);
      check("run_bub", int'(bub_a), 0);
      cycle("run");

      // Load-use on rs, held through the stall cycle
      set_in(1, 8, 1, 0, 8, 1, 0, 1);
      cycle("lu1");
      check("lu_state1", int'(st_a), 1);
      cycle("lu2");
      check("lu_state0", int'(st_a), 0);
      check("lu_count", int'(cnt_a), 1);

      // No false stall: r0, and rt match without UsesRt
      set_in(1, 0, 0, 0, 0, 1, 0, 1);
      cycle("r0");
      set_in(1, 1, 9, 0, 9, 1, 0, 1);
      cycle("norrt");
      check("nostall_state", int'(st_a), 0);
      check("nostall_count", int'(cnt_a), 1);
      set_in(1, 1, 9, 1, 9, 1, 0, 1);
      cycle("rt_lu");
      set_in(1, 1, 2, 0, 3, 0, 0, 1);
      cycle("rt_lu_end");

      // Branch flush, then a restarted flush
      set_in(1, 1, 2, 0, 3, 0, 1, 1);
      cycle("br");
      check("br_state", int'(st_a), 2);
      set_in(1, 1, 2, 0, 3, 0, 0, 0);
      cycle("fl");
      check("fl_state", int'(st_a), 0);
      check("fl_count", int'(cnt_a), 4);
      set_in(1, 1, 2, 0, 3, 0, 1, 1);
      cycle("br2a");
      cycle("br2b");
      set_in(1, 1, 2, 0, 3, 0, 0, 1);
      cycle("br2c");
      check("br2_state", int'(st_a), 0);
      check("br2_count", int'(cnt_a), 7);
      repeat (2) cycle("idle");

      // Fetch wait of 3 cycles, then ready; then br during a wait
      set_in(1, 1, 2, 0, 3, 0, 0, 0);
      repeat (3) cycle("fw");
      check("fw_state", int'(st_a), 3);
      check("fw_count", int'(cnt_a), 10);
      set_in(1, 1, 2, 0, 3, 0, 0, 1);
      cycle("fwrdy");
      check("fwrdy_state", int'(st_a), 0);
      set_in(1, 1, 2, 0, 3, 0, 0, 0);
      cycle("fw2");
      set_in(1, 1, 2, 0, 3, 0, 1, 0);
      cycle("fwbr");
      check("fwbr_state", int'(st_a), 2);

      // br together with lu: flush wins
      set_in(0, 8, 0, 0, 8, 1, 0, 1);
      cycle("rst2");
      set_in(1, 8, 0, 0, 8, 1, 1, 1);
      cycle("brlu");
      check("brlu_state", int'(st_a), 2);

      // Saturation on the 4-bit instance
      set_in(0, 0, 0, 0, 0, 0, 0, 1);
      cycle("rst3");
      set_in(1, 0, 0, 0, 0, 0, 0, 0);
      repeat (20) cycle("sat");
      check("sat_count4", int'(cnt_b), 15);
      check("sat_count16", int'(cnt_a), 20);

      // Random traffic with small register numbers to provoke matches
      for (int i = 0; i < 3000; i++) begin
         set_in($urandom_range(0, 63) != 0,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom),
                int'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 7) == 0,
                $urandom_range(0, 3) != 0);
         cycle("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
